// File: rtl/spgd_ctrl_update_if.sv
// Handshake/bus bundle between the SPGD product source, spgd_ctrl_update and the DAC serializer.
interface spgd_ctrl_update_if #(
  parameter int DATA_WIDTH = 64,
  parameter int CH_W       = 2,
  parameter int DAC_WIDTH  = 14
);
  logic                  prod_valid;
  logic [DATA_WIDTH-1:0] prod_data;
  logic [CH_W-1:0]       prod_chan;
  logic                  commit;
  logic                  dac_ready;
  logic                  dac_valid;
  logic [DAC_WIDTH-1:0]  dac_data;
  logic [CH_W-1:0]       dac_chan;
  logic                  busy;
  logic                  sat_pulse;
  logic                  commit_drop;

  modport master (
    output prod_valid, prod_data, prod_chan, commit, dac_ready,
    input  dac_valid, dac_data, dac_chan, busy, sat_pulse, commit_drop
  );

  modport slave (
    input  prod_valid, prod_data, prod_chan, commit, dac_ready,
    output dac_valid, dac_data, dac_chan, busy, sat_pulse, commit_drop
  );
endinterface

// File: rtl/spgd_ctrl_update.sv
// SPGD control update: per-channel saturating accumulation of correction products,
// commit-triggered snapshot streamed out as offset-binary DAC codes.
module spgd_ctrl_update #(
  parameter int DATA_WIDTH = 64,
  parameter int INT_WIDTH  = 16,
  parameter int NUM_CH     = 4,
  parameter int CH_W       = 2,
  parameter int DAC_WIDTH  = 14
) (
  input  logic             ADC_CLK,
  input  logic             RST,
  spgd_ctrl_update_if.slave bus
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [CH_W:0]                NUM_CH_EXT = (CH_W+1)'(NUM_CH);
  localparam logic [CH_W-1:0]              LAST_IDX   = CH_W'(NUM_CH - 1);
  localparam logic signed [INT_WIDTH-1:0]  CODE_MAX   = INT_WIDTH'(2**(DAC_WIDTH-1) - 1);
  localparam logic signed [INT_WIDTH-1:0]  CODE_MIN   = ~CODE_MAX;
  localparam logic signed [INT_WIDTH-1:0]  CODE_OFF   = INT_WIDTH'(2**(DAC_WIDTH-1));

  state_t                state, state_d;
  logic [CH_W-1:0]       idx, idx_d;
  logic                  snap_load;
  logic [DATA_WIDTH-1:0] acc  [NUM_CH];
  logic [DAC_WIDTH-1:0]  snap [NUM_CH];
  logic [DATA_WIDTH-1:0] acc_sel, acc_new;
  logic [DATA_WIDTH:0]   sum;
  logic                  ovf, chan_ok;
  logic                  sat_q, drop_q;

  // Integer part is the floor of the value; clamp into DAC range, then shift to offset binary.
  function automatic logic [DAC_WIDTH-1:0] to_code(input logic signed [INT_WIDTH-1:0] ipart);
    logic signed [INT_WIDTH-1:0] c;
    c = ipart;
    if (c > CODE_MAX)      c = CODE_MAX;
    else if (c < CODE_MIN) c = CODE_MIN;
    return DAC_WIDTH'(c + CODE_OFF);
  endfunction

  always_comb begin
    chan_ok = ({1'b0, bus.prod_chan} < NUM_CH_EXT);
    acc_sel = acc[bus.prod_chan];
    sum     = {acc_sel[DATA_WIDTH-1], acc_sel} + {bus.prod_data[DATA_WIDTH-1], bus.prod_data};
    ovf     = sum[DATA_WIDTH] ^ sum[DATA_WIDTH-1];
    acc_new = ovf ? {sum[DATA_WIDTH], {(DATA_WIDTH-1){~sum[DATA_WIDTH]}}} : sum[DATA_WIDTH-1:0];
  end

  // Snapshot reads registered acc, so a same-cycle product lands only in acc.
  always_ff @(posedge ADC_CLK) begin
    if (RST) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        acc[CH_W'(i)]  <= '0;
        snap[CH_W'(i)] <= '0;
      end
      sat_q  <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      if (bus.prod_valid && chan_ok)
        acc[bus.prod_chan] <= acc_new;
      if (snap_load)
        for (int unsigned i = 0; i < NUM_CH; i++)
          snap[CH_W'(i)] <= to_code(acc[CH_W'(i)][DATA_WIDTH-1 -: INT_WIDTH]);
      sat_q  <= bus.prod_valid && chan_ok && ovf;
      drop_q <= bus.commit && (state == SEND);
    end
  end

  always_ff @(posedge ADC_CLK) begin
    if (RST) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_d;
      idx   <= idx_d;
    end
  end

  always_comb begin
    state_d   = state;
    idx_d     = idx;
    snap_load = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.commit) begin
          state_d   = SEND;
          idx_d     = '0;
          snap_load = 1'b1;
        end
      end
      SEND: begin
        if (bus.dac_ready) begin
          if (idx == LAST_IDX) begin
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.dac_valid   = (state == SEND);
  assign bus.busy        = (state == SEND);
  assign bus.dac_chan    = idx;
  assign bus.dac_data    = (state == SEND) ? snap[idx] : '0;
  assign bus.sat_pulse   = sat_q;
  assign bus.commit_drop = drop_q;

endmodule

// File: doc/spgd_ctrl_update.md
Name: spgd_ctrl_update

Overview:
- Downstream consumer of the fixed-point multiplier (my_mult) in the SPGD loop.
- Accepts signed Q(INT_WIDTH).(DATA_WIDTH-INT_WIDTH) correction products (gain × dJ × perturbation) tagged by channel.
- Accumulates each product into a per-channel saturating control register.
- On a commit pulse, snapshots all channels and streams them out as offset-binary DAC codes over a valid/ready handshake.

Parameters:
- DATA_WIDTH, 64, width of product input and per-channel accumulators (two's complement fixed point).
- INT_WIDTH, 16, integer bits of the fixed-point format; fraction = DATA_WIDTH-INT_WIDTH.
- NUM_CH, 4, number of control channels (actuators).
- CH_W, 2, channel index width; must satisfy 2^CH_W >= NUM_CH.
- DAC_WIDTH, 14, DAC code width; must satisfy DAC_WIDTH <= INT_WIDTH.

Ports:
- ADC_CLK  in  1  system clock, all logic rising-edge.
- RST  in  1  synchronous, active-high reset.
- prod_valid  in  1  product word valid this cycle; always accepted, no backpressure.
- prod_data  in  DATA_WIDTH  signed fixed-point delta to add.
- prod_chan  in  CH_W  target channel for prod_data.
- commit  in  1  single-cycle request to publish all channels.
- dac_ready  in  1  downstream DAC serializer accepts word.
- dac_valid  out  1  dac_data/dac_chan valid.
- dac_data  out  DAC_WIDTH  offset-binary DAC code.
- dac_chan  out  CH_W  channel of dac_data.
- busy  out  1  high while in SEND.
- sat_pulse  out  1  one-cycle pulse when an accumulate saturated.
- commit_drop  out  1  one-cycle pulse when commit was ignored.

Behaviour:
- Clock/reset: one clock, ADC_CLK. RST is synchronous, active-high. All state changes on the rising edge of ADC_CLK.
- Reset values: all accumulators and snapshots = 0; state = IDLE; dac_valid=0, dac_data=0, dac_chan=0, busy=0, sat_pulse=0, commit_drop=0.
- RST asserted mid-SEND aborts the transfer immediately; the next cycle is IDLE with all outputs at reset values.
- Accumulate: on prod_valid, acc[prod_chan] <= sat(acc[prod_chan] + prod_data), computed at DATA_WIDTH+1 bits.
  - Positive overflow clamps to 0x7FF..F; negative overflow clamps to 0x800..0.
  - sat_pulse is high on the following cycle.
  - Latency: 1 cycle (new value visible the cycle after prod_valid).
- prod_chan >= NUM_CH: word is discarded, no state change.
- Accumulation continues in every state; publishing never blocks or stalls product updates.
- FSM IDLE: when commit=1, snapshot[i] <= acc[i] for all i, taken from registered values (a same-cycle prod_valid update is excluded from the snapshot but still applied to acc). Next state is SEND with idx=0.
- FSM SEND:
  - dac_valid=1, dac_chan=idx, dac_data=code(snapshot[idx]), busy=1. Outputs are registered: first word appears the cycle after commit.
  - Word transfers when dac_valid & dac_ready. dac_data and dac_chan stay stable until the transfer.
  - On transfer with idx<NUM_CH-1: idx+1, next word presented on the following cycle.
  - On transfer with idx=NUM_CH-1: return to IDLE; dac_valid=0 and busy=0 on the next cycle.
  - commit in SEND is ignored and produces a commit_drop pulse on the next cycle.
- Code conversion:
  - I = acc[DATA_WIDTH-1 -: INT_WIDTH], signed, i.e. floor of the value.
  - Clamp I to [-2^(DAC_WIDTH-1), 2^(DAC_WIDTH-1)-1].
  - code = I + 2^(DAC_WIDTH-1), giving unsigned offset-binary.
  - With defaults: 0.0 -> 0x2000; full negative -> 0x0000; full positive -> 0x3FFF.

Test Plan:
- Basic publish: reset, three prod_valid of 0x0001_0000_0000_0000 (+1.0) to ch0, commit, dac_ready=1 -> words ch0=0x2003, ch1=0x2000, ch2=0x2000, ch3=0x2000 on consecutive cycles starting the cycle after commit; busy low after the 4th word.
- Floor and clamp: ch1 += 0xFFFE_8000_0000_0000 (-1.5), ch2 += 0x8000_0000_0000_0000, commit -> ch1=0x1FFE, ch2=0x0000.
- Saturation: ch3 preloaded to 0x7FFF_FFFF_FFFF_FFFF, add +1.0 -> acc unchanged, sat_pulse=1 for exactly 1 cycle; published code 0x3FFF.
- Backpressure and overlap:
  - dac_ready low for 5 cycles while ch0 is presented -> dac_data/dac_chan held constant.
  - prod_valid to ch0 during SEND -> published ch0 unchanged; the next commit reflects the update.
  - commit during SEND -> commit_drop pulse, no restart.
- Reset mid-operation: RST asserted during the ch2 word -> next cycle dac_valid=0, busy=0, all accumulators 0; a subsequent commit publishes 0x2000 on all channels.
- Same-cycle commit/update: prod_valid(+1.0, ch0) coincident with commit in IDLE -> ch0 publishes 0x2000; second commit publishes 0x2001.
